gpio_port: RTL and testbench

Parametrised Arduino-style GPIO port, the successor to the fixed 8-bit write-only port registers. Provides AVR-compatible DDR/PORT/PIN registers, toggle-on-PIN-write, synchronised pad input, and a maskable pin-change interrupt flag. Sits on the core's memory-mapped I/O bus and drives FPGA pads via out/oe pairs.

---
 rtl/gpio_pkg.sv | 10 +
 rtl/gpio_port_if.sv | 22 ++
 rtl/gpio_sync.sv | 17 +
 rtl/gpio_port.sv | 73 +++++++
 tb/tb_gpio_port.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and PCCR bit positions shared by the GPIO port.
package gpio_pkg;
    localparam logic [2:0] ADDR_PIN   = 3'd0;
    localparam logic [2:0] ADDR_DDR   = 3'd1;
    localparam logic [2:0] ADDR_PORT  = 3'd2;
    localparam logic [2:0] ADDR_PCMSK = 3'd3;
    localparam logic [2:0] ADDR_PCCR  = 3'd4;
    localparam int PCIE_BIT = 0;
    localparam int PCIF_BIT = 1;
endpackage

// File: rtl/gpio_port_if.sv
// gpio_port_if: memory-mapped bus plus pad-side signals of one GPIO port.
interface gpio_port_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       bus_addr;
    logic             bus_wr_en;
    logic             bus_rd_en;
    logic [WIDTH-1:0] bus_wr_data;
    logic [WIDTH-1:0] bus_rd_data;
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] pad_out;
    logic [WIDTH-1:0] pad_oe;
    logic             irq;
    modport master (
        output bus_addr, bus_wr_en, bus_rd_en, bus_wr_data, pad_in,
        input  bus_rd_data, pad_out, pad_oe, irq
    );
    modport slave (
        input  bus_addr, bus_wr_en, bus_rd_en, bus_wr_data, pad_in,
        output bus_rd_data, pad_out, pad_oe, irq
    );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage flop chain bringing asynchronous pad levels into the clock domain.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else sync_q <= {sync_q[STAGES-2:0], d_i};
    end
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/gpio_port.sv
// gpio_port: AVR-style DDR/PORT/PIN register block with toggle-on-PIN-write
// and a maskable pin-change interrupt.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_PORT  = '0
) (
    input logic       clock,
    input logic       reset,
    gpio_port_if.slave bus
);
    logic [WIDTH-1:0] sync, prev_q, ddr_q, ddr_d, port_q, port_d, pcmsk_q, pcmsk_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, rd_val;
    logic             pcie_q, pcie_d, pcif_q, pcif_d;
    logic             wr_pin, wr_ddr, wr_port, wr_pcmsk, wr_pccr, pcif_clr;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.pad_in),
        .q_o   (sync)
    );

    always_comb begin
        wr_pin   = bus.bus_wr_en && bus.bus_addr == ADDR_PIN;
        wr_ddr   = bus.bus_wr_en && bus.bus_addr == ADDR_DDR;
        wr_port  = bus.bus_wr_en && bus.bus_addr == ADDR_PORT;
        wr_pcmsk = bus.bus_wr_en && bus.bus_addr == ADDR_PCMSK;
        wr_pccr  = bus.bus_wr_en && bus.bus_addr == ADDR_PCCR;
        // A one-pin port has no PCIF data bit, so its flag can only clear by reset.
        pcif_clr = wr_pccr && |(bus.bus_wr_data & WIDTH'(1 << PCIF_BIT));
        port_d   = wr_pin ? port_q ^ bus.bus_wr_data : wr_port ? bus.bus_wr_data : port_q;
        ddr_d    = wr_ddr ? bus.bus_wr_data : ddr_q;
        pcmsk_d  = wr_pcmsk ? bus.bus_wr_data : pcmsk_q;
        pcie_d   = wr_pccr ? |(bus.bus_wr_data & WIDTH'(1 << PCIE_BIT)) : pcie_q;
        // A fresh masked change outranks a simultaneous write-1-to-clear.
        pcif_d   = |((sync ^ prev_q) & pcmsk_q) || (pcif_q && !pcif_clr);
        rd_val   = bus.bus_addr == ADDR_PIN   ? sync :
                   bus.bus_addr == ADDR_DDR   ? ddr_q :
                   bus.bus_addr == ADDR_PORT  ? port_q :
                   bus.bus_addr == ADDR_PCMSK ? pcmsk_q :
                   bus.bus_addr == ADDR_PCCR  ? WIDTH'((32'(pcif_q) << PCIF_BIT) | (32'(pcie_q) << PCIE_BIT)) :
                   '0;
        rd_data_d = bus.bus_rd_en ? rd_val : rd_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            port_q    <= RESET_PORT;
            ddr_q     <= '0;
            pcmsk_q   <= '0;
            pcie_q    <= 1'b0;
            pcif_q    <= 1'b0;
            prev_q    <= '0;
            rd_data_q <= '0;
        end else begin
            port_q    <= port_d;
            ddr_q     <= ddr_d;
            pcmsk_q   <= pcmsk_d;
            pcie_q    <= pcie_d;
            pcif_q    <= pcif_d;
            prev_q    <= sync;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.bus_rd_data = rd_data_q;
    assign bus.pad_out     = port_q;
    assign bus.pad_oe      = ddr_q;
    assign bus.irq         = pcif_q & pcie_q;
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: scenario tasks with a read-expectation queue checked against registered read data.
module tb_gpio_port;
    localparam int         W    = 8;
    localparam int         SS   = 2;
    localparam logic [7:0] RSTP = 8'h5A;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    gpio_port_if #(.WIDTH(W)) bus ();

    gpio_port #(.WIDTH(W), .SYNC_STAGES(SS), .RESET_PORT(RSTP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.bus_addr = a;
        bus.bus_wr_data = d;
        bus.bus_wr_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus.bus_addr = a;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_rd_en = 1'b0;
        d = bus.bus_rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        bus_write(3'd2, 8'hA5);
        bus_write(3'd1, 8'hFF);
        bus_write(3'd3, 8'hFF);
        bus_write(3'd4, 8'h01);
        exp_q.push_back(8'hA5);
        bus_read(3'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_reset_port got=%h exp=%h", got, exp); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.pad_out !== RSTP) begin errors++; $display("FAIL reset_pad_out got=%h exp=%h", bus.pad_out, RSTP); end
        checks++;
        if (bus.pad_oe !== 8'h00) begin errors++; $display("FAIL reset_pad_oe got=%h exp=00", bus.pad_oe); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
        checks++;
        if (bus.bus_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.bus_rd_data); end
        tick();
        reset = 1'b0;
        tick();
        exp_q.push_back(8'h00);
        bus_read(3'd3, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_pcmsk got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ddr_port();
        logic [7:0] got, exp;
        bus_write(3'd1, 8'h0F);
        checks++;
        if (bus.pad_oe !== 8'h0F) begin errors++; $display("FAIL ddr_pad_oe got=%h exp=0f", bus.pad_oe); end
        bus_write(3'd2, 8'h3C);
        checks++;
        if (bus.pad_out !== 8'h3C) begin errors++; $display("FAIL port_pad_out got=%h exp=3c", bus.pad_out); end
        exp_q.push_back(8'h3C);
        bus_read(3'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL port_read got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h0F);
        bus_read(3'd1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ddr_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_toggle();
        logic [7:0] got, exp;
        bus_write(3'd0, 8'h81);
        checks++;
        if (bus.pad_out !== 8'hBD) begin errors++; $display("FAIL toggle_81 got=%h exp=bd", bus.pad_out); end
        bus_write(3'd0, 8'h00);
        checks++;
        if (bus.pad_out !== 8'hBD) begin errors++; $display("FAIL toggle_00 got=%h exp=bd", bus.pad_out); end
        exp_q.push_back(8'hBD);
        bus_read(3'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL toggle_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reserved_and_rw();
        logic [7:0] got, exp;
        bus_write(3'd5, 8'hFF);
        exp_q.push_back(8'h00);
        bus_read(3'd5, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reserved_read got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hBD);
        bus.bus_addr = 3'd2;
        bus.bus_wr_data = 8'h11;
        bus.bus_wr_en = 1'b1;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (bus.bus_rd_data !== exp) begin errors++; $display("FAIL rw_same_cycle got=%h exp=%h", bus.bus_rd_data, exp); end
        checks++;
        if (bus.pad_out !== 8'h11) begin errors++; $display("FAIL rw_write got=%h exp=11", bus.pad_out); end
        tick();
        checks++;
        if (bus.bus_rd_data !== exp) begin errors++; $display("FAIL rd_hold got=%h exp=%h", bus.bus_rd_data, exp); end
    endtask

    task automatic test_sync_latency();
        logic [7:0] got, exp;
        bus.pad_in = 8'h55;
        for (int k = 1; k <= SS + 2; k++) begin
            exp_q.push_back(k > SS ? 8'h55 : 8'h00);
            bus_read(3'd0, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sync_latency k=%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_pin_change();
        logic [7:0] got, exp;
        bus_write(3'd3, 8'h04);
        bus_write(3'd4, 8'h01);
        bus.pad_in = bus.pad_in ^ 8'h08;
        repeat (SS + 3) tick();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL unmasked_change irq got=%b exp=0", bus.irq); end
        bus.pad_in = bus.pad_in ^ 8'h04;
        repeat (SS) tick();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", bus.irq); end
        tick();
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", bus.irq); end
        exp_q.push_back(8'h03);
        bus_read(3'd4, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL pccr_read got=%h exp=%h", got, exp); end
        bus_write(3'd4, 8'h01);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL pcif_write0_keeps got=%b exp=1", bus.irq); end
        bus_write(3'd4, 8'h03);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL pcif_clear got=%b exp=0", bus.irq); end
        exp_q.push_back(8'h01);
        bus_read(3'd4, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL pccr_after_clear got=%h exp=%h", got, exp); end
    endtask

    task automatic test_collision();
        logic [7:0] got, exp;
        bus.pad_in = bus.pad_in ^ 8'h04;
        repeat (SS) tick();
        bus_write(3'd4, 8'h03);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL collision_irq got=%b exp=1", bus.irq); end
        exp_q.push_back(8'h03);
        bus_read(3'd4, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL collision_pccr got=%h exp=%h", got, exp); end
        bus_write(3'd4, 8'h02);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL post_collision_clear got=%b exp=0", bus.irq); end
    endtask

    initial begin
        bus.bus_addr = 3'd0;
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        bus.bus_wr_data = 8'h00;
        bus.pad_in = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.pad_out !== RSTP) begin errors++; $display("FAIL init_pad_out got=%h exp=%h", bus.pad_out, RSTP); end
        test_reset();
        test_ddr_port();
        test_toggle();
        test_reserved_and_rw();
        test_sync_latency();
        test_pin_change();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
